// File: rtl/te_bucket_scheduler_if.sv
// rtl/te_bucket_scheduler_if.sv - operation, issue, writeback and control signals of the bucket scheduler
interface te_bucket_scheduler_if #(
   parameter int BW = 12,
   parameter int IW = 16,
   parameter int CW = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [BW-1:0] in_bucket;
   logic [IW-1:0] in_id;
   logic          in_asub;
   logic          iss_valid;
   logic [BW-1:0] iss_bucket;
   logic [IW-1:0] iss_id;
   logic          iss_asub;
   logic          wb_valid;
   logic [BW-1:0] wb_bucket;
   logic          flush;
   logic          flush_done;
   logic          busy;
   logic [CW-1:0] conflict_cnt;
   logic [CW-1:0] zero_cnt;

   modport master (
      output in_valid, in_bucket, in_id, in_asub, wb_valid, wb_bucket, flush,
      input  in_ready, iss_valid, iss_bucket, iss_id, iss_asub, flush_done, busy,
             conflict_cnt, zero_cnt
   );

   modport slave (
      input  in_valid, in_bucket, in_id, in_asub, wb_valid, wb_bucket, flush,
      output in_ready, iss_valid, iss_bucket, iss_id, iss_asub, flush_done, busy,
             conflict_cnt, zero_cnt
   );
endinterface

// File: rtl/te_bucket_scheduler.sv
// rtl/te_bucket_scheduler.sv - hazard-aware issue scheduler for the bucket-accumulation point adder
module te_bucket_scheduler #(
   parameter int BW = 12,
   parameter int IW = 16,
   parameter int DQ = 8,
   parameter int CW = 32
) (
   input logic                  clk,
   input logic                  rst_n,
   te_bucket_scheduler_if.slave bus
);
   localparam int              AW     = $clog2(DQ);
   localparam int              NB     = 1 << BW;
   localparam logic [AW:0]     DQ_CNT = (AW+1)'(DQ);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
   typedef struct packed {
      logic [BW-1:0] bucket;
      logic [IW-1:0] id;
      logic          asub;
   } op_t;

   state_e        state_q, state_d;
   logic [NB-1:0] inflight_q, inflight_d;
   logic [BW:0]   cnt_q, cnt_d;
   op_t           mem_q [DQ];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0]   fcnt_q, fcnt_d;
   op_t           iss_q, iss_d;
   logic          iss_valid_q, iss_valid_d;
   logic [CW-1:0] conf_q, conf_d, zero_q, zero_d;

   op_t  head, in_op;
   logic in_ready, accept, r_issue, n_issue, push, zero_hit, wb_ok;

   // Eligibility always looks at the registered bitmap, so a writeback only frees its bucket next cycle.
   always_comb begin
      head     = mem_q[rd_q];
      in_op    = {bus.in_bucket, bus.in_id, bus.in_asub};
      in_ready = (state_q == RUN) && (fcnt_q != DQ_CNT);
      accept   = bus.in_valid && in_ready;
      r_issue  = (fcnt_q != '0) && !inflight_q[head.bucket];
      zero_hit = accept && (in_op.bucket == '0);
      n_issue  = accept && !zero_hit && !inflight_q[in_op.bucket] && !r_issue;
      push     = accept && !zero_hit && !n_issue;
      wb_ok    = bus.wb_valid && inflight_q[bus.wb_bucket];
   end

   always_comb begin
      inflight_d  = inflight_q;
      cnt_d       = cnt_q;
      iss_d       = iss_q;
      iss_valid_d = 1'b0;
      fcnt_d      = fcnt_q;
      conf_d      = conf_q;
      zero_d      = zero_q;
      state_d     = state_q;
      if (wb_ok) begin
         inflight_d[bus.wb_bucket] = 1'b0;
         cnt_d                     = cnt_d - (BW+1)'(1);
      end
      if (r_issue || n_issue) begin
         iss_valid_d               = 1'b1;
         iss_d                     = r_issue ? head : in_op;
         inflight_d[iss_d.bucket]  = 1'b1;
         cnt_d                     = cnt_d + (BW+1)'(1);
      end
      if (push && !r_issue) begin
         fcnt_d = fcnt_q + (AW+1)'(1);
      end else if (!push && r_issue) begin
         fcnt_d = fcnt_q - (AW+1)'(1);
      end
      if (push && (conf_q != '1)) begin
         conf_d = conf_q + CW'(1);
      end
      if (zero_hit && (zero_q != '1)) begin
         zero_d = zero_q + CW'(1);
      end
      unique case (state_q)
         RUN:     if (bus.flush) state_d = DRAIN;
         DRAIN:   if ((fcnt_d == '0) && (cnt_d == '0)) state_d = DONE;
         DONE:    state_d = bus.flush ? DRAIN : RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         inflight_q  <= '0;
         cnt_q       <= '0;
         rd_q        <= '0;
         wr_q        <= '0;
         fcnt_q      <= '0;
         iss_q       <= '0;
         iss_valid_q <= 1'b0;
         conf_q      <= '0;
         zero_q      <= '0;
      end else begin
         state_q     <= state_d;
         inflight_q  <= inflight_d;
         cnt_q       <= cnt_d;
         fcnt_q      <= fcnt_d;
         iss_q       <= iss_d;
         iss_valid_q <= iss_valid_d;
         conf_q      <= conf_d;
         zero_q      <= zero_d;
         if (r_issue) rd_q <= rd_q + AW'(1);
         if (push)    wr_q <= wr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= in_op;
   end

   // A writeback for a bucket that is not in flight means the adder metadata is corrupt.
   always @(posedge clk) begin
      if (rst_n && bus.wb_valid) begin
         assert (inflight_q[bus.wb_bucket]);
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.iss_valid    = iss_valid_q;
   assign bus.iss_bucket   = iss_q.bucket;
   assign bus.iss_id       = iss_q.id;
   assign bus.iss_asub     = iss_q.asub;
   assign bus.flush_done   = (state_q == DONE);
   assign bus.busy         = (fcnt_q != '0) || (cnt_q != '0) || (state_q != RUN);
   assign bus.conflict_cnt = conf_q;
   assign bus.zero_cnt     = zero_q;
endmodule
